stone_renderer: RTL and testbench

STONE_RENDERER -- requirements
Module: stone_renderer

---
 rtl/stone_renderer.sv | 167 ++++++++++++++++
 tb/tb_stone_renderer.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/stone_renderer.sv
// Sprite renderer: scans up to 15 item entries from a synchronous RAM and streams
// a SPRITE x SPRITE block of pixels per visible entry, clipped to the screen.
module stone_renderer #(
    parameter int unsigned SPRITE      = 16,
    parameter int unsigned SCR_W       = 320,
    parameter int unsigned SCR_H       = 240,
    parameter logic [2:0]  COL_STONE   = 3'b111,
    parameter logic [2:0]  COL_GOLD    = 3'b110,
    parameter logic [2:0]  COL_DIAMOND = 3'b011
) (
    input  logic        clock,
    input  logic        resetn,
    input  logic        start,
    input  logic [3:0]  quantity,
    output logic [3:0]  ram_addr,
    input  logic [31:0] ram_q,
    output logic [8:0]  pix_x,
    output logic [7:0]  pix_y,
    output logic [2:0]  pix_colour,
    output logic        plot,
    input  logic        pix_ready,
    output logic        busy,
    output logic        done
);

    typedef enum logic [2:0] {IDLE, ADDR, WAIT, LATCH, DRAW, NEXT, DONE} state_t;

    localparam logic [4:0] LAST  = 5'(SPRITE - 1);
    localparam logic [9:0] W_LIM = 10'(SCR_W);
    localparam logic [9:0] H_LIM = 10'(SCR_H);

    state_t      state_q, state_d;
    logic [3:0]  idx_q, idx_d;
    logic [4:0]  dx_q, dx_d;
    logic [4:0]  dy_q, dy_d;
    logic [8:0]  ex_q, ex_d;
    logic [7:0]  ey_q, ey_d;
    logic [1:0]  etype_q, etype_d;
    logic        evis_q, evis_d;

    logic        plot_q, plot_d;
    logic        done_q, busy_q;
    logic [8:0]  pix_x_q;
    logic [7:0]  pix_y_q;
    logic [2:0]  colour_q, colour_d;
    logic [9:0]  sum_x_d, sum_y_d;
    logic        advance;

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        dx_d    = dx_q;
        dy_d    = dy_q;
        ex_d    = ex_q;
        ey_d    = ey_q;
        etype_d = etype_q;
        evis_d  = evis_q;
        // Clipped slots (plot low) step freely; visible ones wait for the sink.
        advance = plot_q ? pix_ready : 1'b1;

        case (state_q)
            IDLE: begin
                if (start) begin
                    idx_d   = '0;
                    state_d = (quantity == 4'd0) ? DONE : ADDR;
                end
            end
            ADDR:  state_d = WAIT;
            WAIT:  state_d = LATCH;
            LATCH: begin
                ex_d    = ram_q[31:23];
                ey_d    = ram_q[18:11];
                etype_d = ram_q[3:2];
                evis_d  = ram_q[1];
                if (ram_q[1]) begin
                    dx_d    = '0;
                    dy_d    = '0;
                    state_d = DRAW;
                end else begin
                    state_d = NEXT;
                end
            end
            DRAW: begin
                if (advance) begin
                    if (dx_q == LAST) begin
                        dx_d = '0;
                        if (dy_q == LAST) begin
                            dy_d    = '0;
                            state_d = NEXT;
                        end else begin
                            dy_d = dy_q + 5'd1;
                        end
                    end else begin
                        dx_d = dx_q + 5'd1;
                    end
                end
            end
            NEXT: begin
                if (({1'b0, idx_q} + 5'd1) >= {1'b0, quantity}) begin
                    state_d = DONE;
                end else begin
                    idx_d   = idx_q + 4'd1;
                    state_d = ADDR;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        // Outputs are registered from next-state values so they align with state_q.
        sum_x_d = {1'b0, ex_d} + {5'b0, dx_d};
        sum_y_d = {2'b0, ey_d} + {5'b0, dy_d};
        plot_d  = (state_d == DRAW) && (sum_x_d < W_LIM) && (sum_y_d < H_LIM);

        case (etype_d)
            2'd0:    colour_d = COL_STONE;
            2'd1:    colour_d = COL_GOLD;
            default: colour_d = COL_DIAMOND;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!resetn) begin
            state_q  <= IDLE;
            idx_q    <= '0;
            dx_q     <= '0;
            dy_q     <= '0;
            ex_q     <= '0;
            ey_q     <= '0;
            etype_q  <= '0;
            evis_q   <= 1'b0;
            plot_q   <= 1'b0;
            done_q   <= 1'b0;
            busy_q   <= 1'b0;
            pix_x_q  <= '0;
            pix_y_q  <= '0;
            colour_q <= '0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            dx_q     <= dx_d;
            dy_q     <= dy_d;
            ex_q     <= ex_d;
            ey_q     <= ey_d;
            etype_q  <= etype_d;
            evis_q   <= evis_d;
            plot_q   <= plot_d;
            done_q   <= (state_d == DONE);
            busy_q   <= (state_d != IDLE);
            pix_x_q  <= sum_x_d[8:0];
            pix_y_q  <= sum_y_d[7:0];
            colour_q <= colour_d;
        end
    end

    assign ram_addr   = idx_q;
    assign pix_x      = pix_x_q;
    assign pix_y      = pix_y_q;
    assign pix_colour = colour_q;
    assign plot       = plot_q;
    assign busy       = busy_q;
    assign done       = done_q;

    logic unused_bits;
    assign unused_bits = ^{ram_q[22:19], ram_q[10:4], ram_q[0], evis_q};

endmodule

// File: tb/tb_stone_renderer.sv
// Bench for stone_renderer: directed and randomised passes against a pixel-list
// reference model built from the item table, with backpressure and reset aborts.
module tb_stone_renderer;

    localparam int SPRITE = 16;
    localparam int SCR_W  = 320;
    localparam int SCR_H  = 240;

    logic        clock     = 1'b0;
    logic        resetn    = 1'b0;
    logic        start     = 1'b0;
    logic        pix_ready = 1'b1;
    logic [3:0]  quantity  = 4'd0;
    logic [3:0]  ram_addr;
    logic [31:0] ram_q;
    logic [8:0]  pix_x;
    logic [7:0]  pix_y;
    logic [2:0]  pix_colour;
    logic        plot, busy, done;

    logic [31:0] mem [16];
    int vectors     = 0;
    int miscompares = 0;

    typedef struct packed {
        logic [8:0] x;
        logic [7:0] y;
        logic [2:0] c;
    } pix_t;

    pix_t exp_px[$];
    int   exp_cyc;

    always #5 clock = ~clock;

    always @(posedge clock) ram_q <= mem[ram_addr];

    stone_renderer #(
        .SPRITE(SPRITE), .SCR_W(SCR_W), .SCR_H(SCR_H),
        .COL_STONE(3'b111), .COL_GOLD(3'b110), .COL_DIAMOND(3'b011)
    ) dut (
        .clock(clock), .resetn(resetn), .start(start), .quantity(quantity),
        .ram_addr(ram_addr), .ram_q(ram_q), .pix_x(pix_x), .pix_y(pix_y),
        .pix_colour(pix_colour), .plot(plot), .pix_ready(pix_ready),
        .busy(busy), .done(done)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] entry(input int x, input int y, input int t,
                                          input bit vis, input bit mv);
        logic [31:0] e;
        e         = '0;
        e[31:23]  = 9'(x);
        e[22:19]  = 4'($urandom);
        e[18:11]  = 8'(y);
        e[10:4]   = 7'($urandom);
        e[3:2]    = 2'(t);
        e[1]      = vis;
        e[0]      = mv;
        return e;
    endfunction

    function automatic logic [2:0] colour_of(input logic [1:0] t);
        if (t == 2'd0) return 3'b111;
        if (t == 2'd1) return 3'b110;
        return 3'b011;
    endfunction

    // Expected pixel stream and pass length (start cycle through done cycle).
    task automatic build_model(input logic [3:0] q);
        exp_px.delete();
        exp_cyc = 2;
        for (int i = 0; i < int'(q); i++) begin
            logic [31:0] e;
            e = mem[i];
            if (!e[1]) begin
                exp_cyc += 4;
            end else begin
                exp_cyc += SPRITE * SPRITE + 4;
                for (int r = 0; r < SPRITE; r++) begin
                    for (int c = 0; c < SPRITE; c++) begin
                        int px, py;
                        px = int'(e[31:23]) + c;
                        py = int'(e[18:11]) + r;
                        if (px < SCR_W && py < SCR_H)
                            exp_px.push_back({9'(px), 8'(py), colour_of(e[3:2])});
                    end
                end
            end
        end
    endtask

    task automatic run_pass(input string name, input logic [3:0] q, input bit rnd,
                            input int mid_start, input int abort_pix);
        int   cyc, stalls, accepted, n_exp, n_vis;
        bit   prev_stall, got_done;
        pix_t prev, cur, want;
        logic [3:0] visits[$];

        build_model(q);
        n_exp = exp_px.size();
        @(posedge clock); #1;
        quantity = q;
        start = 1'b1;
        pix_ready = 1'b1;
        cyc = 0; stalls = 0; accepted = 0; prev_stall = 0; got_done = 0;
        prev = '0;

        while (cyc < 20000) begin
            @(posedge clock); #1;
            cyc++;
            start = (cyc == mid_start);
            if (visits.size() == 0 || visits[$] != ram_addr) visits.push_back(ram_addr);
            if (done) begin
                got_done = 1;
                break;
            end
            check({name, " busy"}, 32'(busy), 32'd1);
            cur = {pix_x, pix_y, pix_colour};
            if (prev_stall) begin
                check({name, " stall plot"}, 32'(plot), 32'd1);
                check({name, " stall hold"}, 32'(cur), 32'(prev));
            end
            pix_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            prev_stall = 0;
            if (plot) begin
                if (pix_ready) begin
                    if (exp_px.size() == 0) begin
                        check({name, " extra pixel"}, 32'(accepted + 1), 32'(n_exp));
                    end else begin
                        want = exp_px.pop_front();
                        check({name, " pixel"}, 32'(cur), 32'(want));
                    end
                    accepted++;
                    if (abort_pix > 0 && accepted == abort_pix) begin
                        resetn = 1'b0;
                        @(posedge clock); #1;
                        check({name, " abort plot"}, 32'(plot), 32'd0);
                        check({name, " abort busy"}, 32'(busy), 32'd0);
                        check({name, " abort done"}, 32'(done), 32'd0);
                        check({name, " abort addr"}, 32'(ram_addr), 32'd0);
                        check({name, " abort pixel"}, 32'({pix_x, pix_y, pix_colour}), 32'd0);
                        resetn = 1'b1;
                        for (int k = 0; k < 4; k++) begin
                            @(posedge clock); #1;
                            check({name, " abort no done"}, 32'(done), 32'd0);
                        end
                        return;
                    end
                end else begin
                    stalls++;
                    prev_stall = 1;
                    prev = cur;
                end
            end
        end

        start = 1'b0;
        check({name, " done seen"}, 32'(got_done), 32'd1);
        check({name, " latency"}, 32'(cyc + 1), 32'(exp_cyc + stalls));
        check({name, " pixel count"}, 32'(accepted), 32'(n_exp));
        n_vis = (q == 4'd0) ? 1 : int'(q);
        check({name, " addr visits"}, 32'(visits.size()), 32'(n_vis));
        for (int k = 0; k < visits.size() && k < n_vis; k++)
            check({name, " addr order"}, 32'(visits[k]), 32'(k));
        @(posedge clock); #1;
        check({name, " done pulse"}, 32'(done), 32'd0);
        check({name, " idle busy"}, 32'(busy), 32'd0);
        if (mid_start > 0) begin
            for (int k = 0; k < 5; k++) begin
                @(posedge clock); #1;
                check({name, " single done"}, 32'(done), 32'd0);
                check({name, " no restart"}, 32'(busy), 32'd0);
            end
        end
    endtask

    initial begin
        for (int i = 0; i < 16; i++) mem[i] = '0;

        resetn = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        check("reset plot", 32'(plot), 32'd0);
        check("reset busy", 32'(busy), 32'd0);
        check("reset done", 32'(done), 32'd0);
        check("reset addr", 32'(ram_addr), 32'd0);
        check("reset pixel", 32'({pix_x, pix_y, pix_colour}), 32'd0);
        resetn = 1'b1;

        mem[0] = entry(100, 50, 1, 1'b1, 1'b0);
        run_pass("gold", 4'd1, 1'b0, 0, 0);

        mem[0] = entry(10, 10, 0, 1'b1, 1'b0);
        mem[1] = entry(40, 40, 0, 1'b0, 1'b0);
        mem[2] = entry(200, 100, 0, 1'b1, 1'b1);
        run_pass("skip", 4'd3, 1'b0, 0, 0);

        mem[0] = entry(310, 230, 2, 1'b1, 1'b0);
        run_pass("clip", 4'd1, 1'b0, 0, 0);

        mem[0] = entry(100, 50, 1, 1'b1, 1'b0);
        run_pass("bp gold", 4'd1, 1'b1, 0, 0);

        run_pass("qzero", 4'd0, 1'b0, 0, 0);

        mem[0] = entry(10, 10, 0, 1'b1, 1'b0);
        mem[1] = entry(40, 40, 0, 1'b0, 1'b0);
        mem[2] = entry(200, 100, 3, 1'b1, 1'b1);
        run_pass("bp skip", 4'd3, 1'b1, 0, 0);
        run_pass("mid start", 4'd3, 1'b0, 300, 0);

        mem[0] = entry(20, 20, 1, 1'b1, 1'b0);
        mem[1] = entry(60, 60, 2, 1'b1, 1'b0);
        run_pass("abort", 4'd2, 1'b0, 0, 37);
        run_pass("after abort", 4'd2, 1'b0, 0, 0);

        for (int p = 0; p < 4; p++) begin
            for (int i = 0; i < 16; i++)
                mem[i] = entry($urandom_range(0, 511), $urandom_range(0, 255),
                               $urandom_range(0, 3), $urandom_range(0, 3) != 0,
                               1'($urandom_range(0, 1)));
            run_pass("random", 4'($urandom_range(1, 15)), p[0], 0, 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
